olivia_fetch_unit: RTL and testbench
====================================

# olivia_fetch_unit

Parametrised instruction-fetch stage for the Olivia LEGv8 core, replacing the bare PC + adder + combinational instruction-memory path of the single-cycle design. It owns the PC and issues requests to a synchronous instruction memory with one-cycle response latency. Fetched instructions are buffered in a prefetch FIFO and handed to decode over a valid/ready handshake. It adds branch redirect with flush of buffered and in-flight fetches, backpressure from decode, and configurable widths and depth.

## Interface
- ADDR_WIDTH, 64, PC and memory address width
- INST_WIDTH, 32, instruction word width
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, ≥ 2
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, byte increment per sequential fetch
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  ADDR_WIDTH  fetch address (current PC)
- imem_rsp_valid  in  1  response for request accepted on previous edge
- imem_rsp_data  in  INST_WIDTH  fetched instruction
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_target  in  ADDR_WIDTH  new PC
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  INST_WIDTH  instruction at FIFO head
- inst_pc  out  ADDR_WIDTH  address of inst_data
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries

## Operation
- Reset (async, active-high): pc = RESET_PC, FIFO empty, inflight = 0.
  - While rst is high: imem_req_valid = 0, imem_req_addr = RESET_PC, inst_valid = 0, inst_data = 0, inst_pc = 0, fifo_count = 0.
- inflight flag: set on an edge where imem_req_valid && imem_req_ready, cleared otherwise. At most one request is outstanding.
- Issue rule: imem_req_valid = !redirect_valid && (fifo_count + inflight < FIFO_DEPTH).
  - The count is conservative and ignores a same-cycle pop, so the FIFO can never overflow.
- PC update priority:
  - redirect_valid: pc ← redirect_target.
  - Else, request accepted: pc ← pc + PC_STEP, modulo 2^ADDR_WIDTH (wraps silently).
  - Else: hold.
- Each request records its PC in a one-entry side register. The response pushes {data, pc} into the FIFO.
- Redirect in the same cycle as imem_rsp_valid: the response is discarded and not pushed.
- Redirect flushes the FIFO on that edge; fifo_count = 0 next cycle.
- inst_valid = (fifo_count ≠ 0) && !redirect_valid. inst_data and inst_pc show the head entry and are forced to 0 when inst_valid = 0.
- Pop happens on inst_valid && inst_ready.
- Push and pop on the same edge: count unchanged, order preserved.
- redirect_target alignment is not checked; the PC is used as given.
- Reset asserted mid-operation: everything returns to reset values immediately, including any in-flight response, which is ignored. A response arriving while rst is high is dropped.

## Timing
- Request to decode latency: request accepted at edge E, response valid during cycle E→E+1, pushed at E+1, inst_valid high after E+1 (2 edges).
- After rst deasserts with imem_req_ready = 1:
  - First request issued in the first cycle with rst low, to RESET_PC.
  - First inst_valid two edges later.
- Redirect asserted for one cycle at edge R:
  - No request in cycle R.
  - Request to target in cycle R+1.
  - Target instruction reaches decode 2 edges after that request.
- With FIFO_DEPTH ≥ 4 and inst_ready and imem_req_ready held high, throughput is one instruction per cycle.
- When fifo_count + inflight = FIFO_DEPTH, imem_req_valid drops in the same cycle (combinational).
- No combinational path from inst_ready to imem_req_valid. Paths exist from redirect_valid to imem_req_valid and to inst_valid.

## Test plan
- Reset release, ready always high, memory returns data = addr: inst_pc sequence 0, 4, 8, 12…, inst_data equal to inst_pc, first inst_valid 2 edges after first request, one instruction per cycle thereafter.
- Backpressure: inst_ready = 0 for 10 cycles with FIFO_DEPTH = 4.
  - fifo_count saturates at 4 and imem_req_valid falls with no overflow.
  - On release, PCs continue contiguous with no gaps or duplicates.
- Redirect to 0x100 while the FIFO holds 3 entries and a response is in flight:
  - In-flight response dropped; FIFO empty next cycle.
  - Next request address is 0x100; next delivered inst_pc = 0x100.
- imem_req_ready toggling 1,0,1,0: PC advances only on accepted edges; delivered PCs strictly +4 each.
- Wrap: RESET_PC = 2^64 − 8 gives inst_pc sequence FFFF_FFFF_FFFF_FFF8, FFFF_FFFF_FFFF_FFFC, 0, 4.
- Asynchronous reset asserted mid-stream between edges:
  - inst_valid = 0, imem_req_valid = 0, fifo_count = 0 immediately.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/olivia_fetch_unit.sv
// -----------------------------------------------------------------------------
// olivia_fetch_unit
//
// Instruction-fetch stage for the Olivia LEGv8 core. Owns the PC, issues one
// request at a time to a synchronous instruction memory (one-cycle response
// latency), buffers returned instructions together with their PCs in a small
// prefetch FIFO and hands them to decode over a valid/ready handshake. A branch
// redirect flushes the FIFO, discards any response returning in the same cycle
// and restarts fetch at the redirect target.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   imem_req_valid    : fetch request to instruction memory
//   imem_req_ready    : memory accepts the request this cycle
//   imem_req_addr     : fetch address (current PC)
//   imem_rsp_valid    : response for the request accepted on the previous edge
//   imem_rsp_data     : fetched instruction word
//   redirect_valid    : taken branch/jump; flush and refetch
//   redirect_target   : new PC
//   inst_valid        : instruction available to decode
//   inst_ready        : decode accepts the instruction
//   inst_data         : instruction at FIFO head (0 when inst_valid is low)
//   inst_pc           : address of inst_data (0 when inst_valid is low)
//   fifo_count        : number of buffered instructions
// -----------------------------------------------------------------------------
module olivia_fetch_unit #(
  parameter int unsigned            ADDR_WIDTH = 64,
  parameter int unsigned            INST_WIDTH = 32,
  parameter int unsigned            FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0]  PC_STEP    = ADDR_WIDTH'(4)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [ADDR_WIDTH-1:0]         imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [INST_WIDTH-1:0]         imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_target,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INST_WIDTH-1:0]         inst_data,
  output logic [ADDR_WIDTH-1:0]         inst_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Control state (asynchronously reset)
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Data state (no reset; qualified by the control state above)
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [INST_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] data_mem_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_d   [FIFO_DEPTH];

  logic [CNT_W:0]        occupancy;
  logic                  req_fire;
  logic                  push;
  logic                  pop;

  // ---------------------------------------------------------------------------
  // Request side: issue, PC update, in-flight tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    // Occupancy counts the outstanding request as a reserved slot and ignores
    // a same-cycle pop, so a response always finds room in the FIFO. This also
    // keeps inst_ready out of the request path.
    occupancy      = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    imem_req_valid = !rst && !redirect_valid &&
                     (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (req_fire) begin
      pc_d = pc_q + PC_STEP;
    end

    inflight_d = req_fire;
    req_pc_d   = req_fire ? pc_q : req_pc_q;
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO: push on response, pop on decode handshake, flush on redirect
  // ---------------------------------------------------------------------------
  always_comb begin
    // A response only belongs to us if a request was accepted on the previous
    // edge; a response racing a redirect is stale and dropped.
    push       = imem_rsp_valid && inflight_q && !redirect_valid;
    inst_valid = (count_q != '0) && !redirect_valid;
    pop        = inst_valid && inst_ready;

    inst_data  = inst_valid ? data_mem_q[rd_ptr_q] : '0;
    inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q]   : '0;
    fifo_count = count_q;

    data_mem_d = data_mem_q;
    pc_mem_d   = pc_mem_q;
    if (push) begin
      data_mem_d[wr_ptr_q] = imem_rsp_data;
      pc_mem_d[wr_ptr_q]   = req_pc_q;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q   <= req_pc_d;
    data_mem_q <= data_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

endmodule

// File: tb/tb_olivia_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_olivia_fetch_unit
//
// Directed bench for olivia_fetch_unit. Two instances share clock and reset:
// a default one (RESET_PC = 0) and one starting near the top of the address
// space to exercise PC wrap. Each has a one-cycle-latency memory model that
// returns the low word of the request address as data. Expected decode PCs
// are queued as each phase is started; per-instance monitors pop and compare
// on every decode handshake.
// -----------------------------------------------------------------------------
module tb_olivia_fetch_unit;

  localparam int AW    = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          inst_valid, inst_ready;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic [CW-1:0] fifo_count;

  logic          w_req_valid;
  logic [AW-1:0] w_req_addr;
  logic          w_rsp_valid;
  logic [IW-1:0] w_rsp_data;
  logic          w_inst_valid, w_inst_ready;
  logic [IW-1:0] w_inst_data;
  logic [AW-1:0] w_inst_pc;
  logic [CW-1:0] w_fifo_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] w_exp_q[$];
  logic [AW-1:0] mon_e, w_mon_e;

  always #5 clk = ~clk;

  olivia_fetch_unit #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .FIFO_DEPTH(DEPTH),
    .RESET_PC(64'h0), .PC_STEP(64'd4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fifo_count(fifo_count)
  );

  olivia_fetch_unit #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .FIFO_DEPTH(DEPTH),
    .RESET_PC(WRAP_PC), .PC_STEP(64'd4)
  ) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_target(64'h0),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
    .inst_data(w_inst_data), .inst_pc(w_inst_pc), .fifo_count(w_fifo_count)
  );

  // Instruction memory models: data = low word of address, one-cycle latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
      w_rsp_valid    <= 1'b0;
      w_rsp_data     <= '0;
    end else begin
      imem_rsp_valid <= imem_req_valid && imem_req_ready;
      imem_rsp_data  <= imem_req_addr[IW-1:0];
      w_rsp_valid    <= w_req_valid;
      w_rsp_data     <= w_req_addr[IW-1:0];
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%h, expected 0x%h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL main_unexpected (cycle %0d): got pc 0x%h, expected nothing", cyc, inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("main_pc", inst_pc, mon_e);
        check("main_data", {32'h0, inst_data}, {32'h0, mon_e[IW-1:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w_inst_valid && w_inst_ready) begin
      if (w_exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wrap_unexpected (cycle %0d): got pc 0x%h, expected nothing", cyc, w_inst_pc);
      end else begin
        w_mon_e = w_exp_q.pop_front();
        check("wrap_pc", w_inst_pc, w_mon_e);
        check("wrap_data", {32'h0, w_inst_data}, {32'h0, w_mon_e[IW-1:0]});
      end
    end
  end

  // Advance to 1 time unit after the rising edge that starts cycle n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    imem_req_ready  = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b1;
    w_inst_ready    = 1'b1;
    #1 rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_wrap_addr", w_req_addr, WRAP_PC);

    // Release: cycle 0 is the first cycle with rst low
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(4 * i));
    w_exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
    w_exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    w_exp_q.push_back(64'h0);
    w_exp_q.push_back(64'h4);
    #1;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 0);
    check("c0_inst_valid", inst_valid, 0);
    check("wrap_first_addr", w_req_addr, WRAP_PC);
    goto(1);
    #1 check("c1_inst_valid", inst_valid, 0);
    goto(2);
    #1 check("first_inst_valid", inst_valid, 1);
    for (int c = 3; c <= 9; c++) begin
      goto(c);
      if (c == 6) w_inst_ready = 1'b0;
      #1 check("throughput_valid", inst_valid, 1);
    end

    // Backpressure for 10 cycles
    goto(10);
    inst_ready = 1'b0;
    goto(19);
    #1;
    check("bp_fifo_count", fifo_count, 4);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_req_addr", imem_req_addr, 48);
    check("bp_inst_valid", inst_valid, 1);
    check("bp_head_pc", inst_pc, 32);

    // Release: contiguous continuation
    goto(20);
    inst_ready = 1'b1;
    for (int i = 8; i < 14; i++) exp_q.push_back(64'(4 * i));

    // Stall decode so the FIFO holds 3 entries with a response in flight
    goto(26);
    inst_ready = 1'b0;
    goto(27);
    #1;
    check("pre_redir_count", fifo_count, 3);
    check("pre_redir_req_valid", imem_req_valid, 0);
    redirect_valid  = 1'b1;
    redirect_target = 64'h100;
    #1;
    check("redir_req_valid", imem_req_valid, 0);
    check("redir_inst_valid", inst_valid, 0);
    check("redir_inst_data", inst_data, 0);
    check("redir_inst_pc", inst_pc, 0);
    for (int i = 0; i < 9; i++) exp_q.push_back(64'h100 + 64'(4 * i));

    goto(28);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    check("post_redir_count", fifo_count, 0);
    check("post_redir_req_valid", imem_req_valid, 1);
    check("post_redir_addr", imem_req_addr, 64'h100);

    // Memory ready toggling 1,0,1,0: PC moves only on accepted edges
    for (int c = 29; c <= 39; c++) begin
      goto(c);
      imem_req_ready = (c % 2 == 0);
      #1;
      check("toggle_req_valid", imem_req_valid, 1);
      check("toggle_addr", imem_req_addr, 64'h100 + 64'(4 * ((c - 27) / 2)));
    end
    goto(40);
    imem_req_ready = 1'b1;

    // Asynchronous reset between edges
    goto(45);
    #2 rst = 1'b1;
    #1;
    check("async_inst_valid", inst_valid, 0);
    check("async_req_valid", imem_req_valid, 0);
    check("async_fifo_count", fifo_count, 0);
    check("async_req_addr", imem_req_addr, 0);
    check("async_inst_data", inst_data, 0);
    goto(47);
    goto(48);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(64'(4 * i));
    #1;
    check("restart_req_valid", imem_req_valid, 1);
    check("restart_req_addr", imem_req_addr, 0);
    goto(50);
    #1 check("restart_inst_valid", inst_valid, 1);
    goto(56);
    inst_ready = 1'b0;
    goto(60);
    #1;
    check("main_queue_left", 64'(exp_q.size()), 0);
    check("wrap_queue_left", 64'(w_exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
